// File: rtl/relobi_a_other_decoder.sv
// Purpose: relOBI A-channel "other" decoder; Hsiao SECDED check/correct of {we, be, aid, a_optional}.
// Latency: 1 cycle (single output register); 1 beat/cycle when out_ready_i stays high.
// Backpressure: in_ready_o = !out_valid_o | out_ready_i; a stalled output holds every output stable.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   in_valid_i / in_ready_o       input beat handshake
//   we_i, be_i, aid_i,            received payload (possibly corrupted) and its ECC word
//   a_optional_i, other_ecc_i
//   out_valid_o / out_ready_i     output beat handshake
//   we_o, be_o, aid_o,            corrected payload
//   a_optional_o
//   corr_o, uncorr_o              per-beat status of the beat on the output
//   clear_i                       clears the counters and the sticky fault
//   corr_cnt_o, uncorr_cnt_o      saturating counts of corrected / uncorrectable beats
//   fault_o                       sticky uncorrectable-error flag
module relobi_a_other_decoder #(
  parameter int DataWidth     = 32,
  parameter int IdWidth       = 1,
  parameter int OptWidth      = 1,
  parameter int CntWidth      = 16,
  parameter int OtherWidth    = 1 + DataWidth / 8 + IdWidth + OptWidth,
  // Smallest r with enough odd-weight (>=3) columns: 2^(r-1) - r >= OtherWidth.
  parameter int OtherEccWidth = ((2 ** 2) - 3 >= OtherWidth) ? 3 :
                                ((2 ** 3) - 4 >= OtherWidth) ? 4 :
                                ((2 ** 4) - 5 >= OtherWidth) ? 5 :
                                ((2 ** 5) - 6 >= OtherWidth) ? 6 :
                                ((2 ** 6) - 7 >= OtherWidth) ? 7 : 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     we_i,
  input  logic [DataWidth/8-1:0]   be_i,
  input  logic [IdWidth-1:0]       aid_i,
  input  logic [OptWidth-1:0]      a_optional_i,
  input  logic [OtherEccWidth-1:0] other_ecc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     we_o,
  output logic [DataWidth/8-1:0]   be_o,
  output logic [IdWidth-1:0]       aid_o,
  output logic [OptWidth-1:0]      a_optional_o,
  output logic                     corr_o,
  output logic                     uncorr_o,
  input  logic                     clear_i,
  output logic [CntWidth-1:0]      corr_cnt_o,
  output logic [CntWidth-1:0]      uncorr_cnt_o,
  output logic                     fault_o
);

  localparam int BeW = DataWidth / 8;
  localparam int EW  = OtherEccWidth;
  localparam int HW  = OtherWidth * EW;

  // H-matrix payload columns: odd-weight vectors of weight >= 3, taken in order of
  // increasing weight, then increasing value. Column n belongs to payload bit n
  // (bit 0 = a_optional LSB). ECC bits use the identity columns.
  function automatic logic [HW-1:0] gen_cols();
    logic [HW-1:0] cols;
    int            n;
    cols = '0;
    n    = 0;
    for (int w = 3; w <= EW; w += 2) begin
      for (int v = 0; v < (2 ** EW); v++) begin
        if ($countones(v) == w && n < OtherWidth) begin
          cols = cols | (HW'(v) << (n * EW));
          n++;
        end
      end
    end
    return cols;
  endfunction

  localparam logic [HW-1:0] HCols = gen_cols();

  logic [OtherWidth-1:0] payload;
  logic [OtherWidth-1:0] flip;
  logic [OtherWidth-1:0] payload_fix;
  logic [EW-1:0]         synd_acc [OtherWidth+1];
  logic [EW-1:0]         syndrome;
  logic                  ecc_hit;
  logic                  corr_evt;
  logic                  uncorr_evt;
  logic                  accept;

  assign payload = {we_i, be_i, aid_i, a_optional_i};

  // Syndrome = received ECC xor the columns of all set payload bits.
  assign synd_acc[0] = other_ecc_i;
  for (genvar i = 0; i < OtherWidth; i++) begin : g_col
    assign synd_acc[i+1] = synd_acc[i] ^ (payload[i] ? HCols[i*EW +: EW] : '0);
    assign flip[i]       = (syndrome == HCols[i*EW +: EW]);
  end
  assign syndrome = synd_acc[OtherWidth];

  // A single flipped ECC bit shows up as a weight-1 syndrome; payload stays as is.
  assign ecc_hit     = $onehot(syndrome);
  // Payload columns are all odd weight, so a match already implies odd weight.
  assign corr_evt    = (|flip) | ecc_hit;
  assign uncorr_evt  = (|syndrome) & ~corr_evt;
  assign payload_fix = payload ^ flip;

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  logic                  out_valid_q, out_valid_d;
  logic [OtherWidth-1:0] payload_q, payload_d;
  logic                  corr_q, corr_d;
  logic                  uncorr_q, uncorr_d;
  logic [CntWidth-1:0]   corr_cnt_q, corr_cnt_d;
  logic [CntWidth-1:0]   uncorr_cnt_q, uncorr_cnt_d;
  logic                  fault_q, fault_d;

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    corr_d      = corr_q;
    uncorr_d    = uncorr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      payload_d   = payload_fix;
      corr_d      = corr_evt;
      uncorr_d    = uncorr_evt;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Counters: clear wins over the stored value, but an event in the same cycle
  // still counts, so clear+event leaves the counter at 1.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    fault_d      = fault_q;
    if (clear_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      fault_d      = 1'b0;
    end
    if (accept && corr_evt) begin
      if (clear_i)                              corr_cnt_d = CntWidth'(1);
      else if (corr_cnt_q != {CntWidth{1'b1}})  corr_cnt_d = corr_cnt_q + CntWidth'(1);
    end
    if (accept && uncorr_evt) begin
      fault_d = 1'b1;
      if (clear_i)                                uncorr_cnt_d = CntWidth'(1);
      else if (uncorr_cnt_q != {CntWidth{1'b1}})  uncorr_cnt_d = uncorr_cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      payload_q    <= '0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      fault_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      payload_q    <= payload_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      fault_q      <= fault_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign a_optional_o = payload_q[OptWidth-1:0];
  assign aid_o        = payload_q[OptWidth +: IdWidth];
  assign be_o         = payload_q[OptWidth+IdWidth +: BeW];
  assign we_o         = payload_q[OtherWidth-1];
  assign corr_o       = corr_q;
  assign uncorr_o     = uncorr_q;
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_relobi_a_other_decoder.sv
// Bench for relobi_a_other_decoder with DataWidth=32, IdWidth=1, OptWidth=1 (7 payload, 5 ECC bits).
// H columns used for hand-computed ECC: opt=5'h07 aid=5'h0B be0=5'h0D be1=5'h0E be2=5'h13 be3=5'h15 we=5'h16.
// Clean {we=1,be=A,aid=1,opt=0} -> ECC 5'h06; clean {we=0,be=F,aid=0,opt=1} -> ECC 5'h02.
module tb_relobi_a_other_decoder;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [0:0]  aid_i;
  logic [0:0]  opt_i;
  logic [4:0]  ecc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        we_o;
  logic [3:0]  be_o;
  logic [0:0]  aid_o;
  logic [0:0]  opt_o;
  logic        corr_o;
  logic        uncorr_o;
  logic        clear_i;
  logic [15:0] corr_cnt_o;
  logic [15:0] uncorr_cnt_o;
  logic        fault_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  relobi_a_other_decoder #(
    .DataWidth (32),
    .IdWidth   (1),
    .OptWidth  (1),
    .CntWidth  (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .we_i         (we_i),
    .be_i         (be_i),
    .aid_i        (aid_i),
    .a_optional_i (opt_i),
    .other_ecc_i  (ecc_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .we_o         (we_o),
    .be_o         (be_o),
    .aid_o        (aid_o),
    .a_optional_o (opt_o),
    .corr_o       (corr_o),
    .uncorr_o     (uncorr_o),
    .clear_i      (clear_i),
    .corr_cnt_o   (corr_cnt_o),
    .uncorr_cnt_o (uncorr_cnt_o),
    .fault_o      (fault_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one clock edge.
  task automatic send(input logic we, input logic [3:0] be, input logic aid,
                      input logic opt, input logic [4:0] ecc);
    we_i       = we;
    be_i       = be;
    aid_i      = aid;
    opt_i      = opt;
    ecc_i      = ecc;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    clear_i     = 1'b0;
    we_i        = 1'b0;
    be_i        = 4'h0;
    aid_i       = 1'b0;
    opt_i       = 1'b0;
    ecc_i       = 5'h00;
    step();
    step();

    // Reset state
    check("rst_valid",  32'(out_valid_o),  32'h0);
    check("rst_ready",  32'(in_ready_o),   32'h1);
    check("rst_ccnt",   32'(corr_cnt_o),   32'h0);
    check("rst_ucnt",   32'(uncorr_cnt_o), 32'h0);
    check("rst_fault",  32'(fault_o),      32'h0);
    rst_ni = 1'b1;
    step();

    // Clean beat
    send(1'b1, 4'hA, 1'b1, 1'b0, 5'h06);
    check("clean_valid", 32'(out_valid_o), 32'h1);
    check("clean_we",    32'(we_o),        32'h1);
    check("clean_be",    32'(be_o),        32'hA);
    check("clean_aid",   32'(aid_o),       32'h1);
    check("clean_opt",   32'(opt_o),       32'h0);
    check("clean_corr",  32'(corr_o),      32'h0);
    check("clean_uncorr",32'(uncorr_o),    32'h0);
    check("clean_ccnt",  32'(corr_cnt_o),  32'h0);

    // be bit1 flipped -> corrected
    send(1'b1, 4'h8, 1'b1, 1'b0, 5'h06);
    check("be1_be",   32'(be_o),       32'hA);
    check("be1_corr", 32'(corr_o),     32'h1);
    check("be1_ccnt", 32'(corr_cnt_o), 32'h1);

    // ECC bit0 flipped -> payload unchanged, corrected
    send(1'b1, 4'hA, 1'b1, 1'b0, 5'h07);
    check("ecc_be",   32'(be_o),       32'hA);
    check("ecc_we",   32'(we_o),       32'h1);
    check("ecc_corr", 32'(corr_o),     32'h1);
    check("ecc_ccnt", 32'(corr_cnt_o), 32'h2);

    // a_optional flipped on second pattern -> corrected to 1
    send(1'b0, 4'hF, 1'b0, 1'b0, 5'h02);
    check("opt_opt",  32'(opt_o),      32'h1);
    check("opt_be",   32'(be_o),       32'hF);
    check("opt_corr", 32'(corr_o),     32'h1);
    check("opt_ccnt", 32'(corr_cnt_o), 32'h3);

    // we and aid flipped -> even syndrome, uncorrectable, raw payload
    send(1'b0, 4'hA, 1'b0, 1'b0, 5'h06);
    check("dbl_uncorr", 32'(uncorr_o),     32'h1);
    check("dbl_corr",   32'(corr_o),       32'h0);
    check("dbl_we",     32'(we_o),         32'h0);
    check("dbl_aid",    32'(aid_o),        32'h0);
    check("dbl_ucnt",   32'(uncorr_cnt_o), 32'h1);
    check("dbl_fault",  32'(fault_o),      32'h1);
    check("dbl_ccnt",   32'(corr_cnt_o),   32'h3);

    // Odd syndrome 5'h19 matching no column -> uncorrectable
    send(1'b1, 4'hA, 1'b1, 1'b0, 5'h1F);
    check("odd_uncorr", 32'(uncorr_o),     32'h1);
    check("odd_corr",   32'(corr_o),       32'h0);
    check("odd_be",     32'(be_o),         32'hA);
    check("odd_ucnt",   32'(uncorr_cnt_o), 32'h2);

    // Fault is sticky across a clean beat
    send(1'b1, 4'hA, 1'b1, 1'b0, 5'h06);
    check("sticky_fault",  32'(fault_o),  32'h1);
    check("sticky_uncorr", 32'(uncorr_o), 32'h0);

    // Clear without a beat
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("clr_ccnt",  32'(corr_cnt_o),   32'h0);
    check("clr_ucnt",  32'(uncorr_cnt_o), 32'h0);
    check("clr_fault", 32'(fault_o),      32'h0);

    // Back-pressure: one corrected beat accepted, then an uncorrectable beat waits
    out_ready_i = 1'b0;
    send(1'b0, 4'hF, 1'b0, 1'b0, 5'h02);
    check("bp_valid", 32'(out_valid_o), 32'h1);
    we_i = 1'b0; be_i = 4'hA; aid_i = 1'b0; opt_i = 1'b0; ecc_i = 5'h06;
    in_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_ready", 32'(in_ready_o),   32'h0);
      check("bp_opt",   32'(opt_o),        32'h1);
      check("bp_ucnt",  32'(uncorr_cnt_o), 32'h0);
    end
    check("bp_be",   32'(be_o),       32'hF);
    check("bp_ccnt", 32'(corr_cnt_o), 32'h1);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    check("bp_drain", 32'(out_valid_o), 32'h0);

    // Saturation of the corrected counter
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    we_i = 1'b1; be_i = 4'h8; aid_i = 1'b1; opt_i = 1'b0; ecc_i = 5'h06;
    in_valid_i = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    check("sat_max", 32'(corr_cnt_o), 32'hFFFF);
    send(1'b1, 4'h8, 1'b1, 1'b0, 5'h06);
    check("sat_hold", 32'(corr_cnt_o), 32'hFFFF);
    check("sat_corr", 32'(corr_o),     32'h1);

    // Clear coinciding with a corrected beat -> 1
    clear_i = 1'b1;
    send(1'b1, 4'h8, 1'b1, 1'b0, 5'h06);
    clear_i = 1'b0;
    check("clrc_ccnt",  32'(corr_cnt_o), 32'h1);
    check("clrc_fault", 32'(fault_o),    32'h0);

    // Clear coinciding with an uncorrectable beat
    clear_i = 1'b1;
    send(1'b0, 4'hA, 1'b0, 1'b0, 5'h06);
    clear_i = 1'b0;
    check("clru_ccnt",  32'(corr_cnt_o),   32'h0);
    check("clru_ucnt",  32'(uncorr_cnt_o), 32'h1);
    check("clru_fault", 32'(fault_o),      32'h1);

    // Reset while a beat is held
    out_ready_i = 1'b0;
    send(1'b1, 4'hA, 1'b1, 1'b0, 5'h06);
    check("mrst_pre", 32'(out_valid_o), 32'h1);
    rst_ni = 1'b0;
    step();
    check("mrst_valid", 32'(out_valid_o),  32'h0);
    check("mrst_be",    32'(be_o),         32'h0);
    check("mrst_ucnt",  32'(uncorr_cnt_o), 32'h0);
    check("mrst_ccnt",  32'(corr_cnt_o),   32'h0);
    check("mrst_fault", 32'(fault_o),      32'h0);
    check("mrst_ready", 32'(in_ready_o),   32'h1);
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
